// File: rtl/exec_core.sv
// exec_core: single-cycle MIPS-style execution core holding the PC, decoding
// the instruction, running the ALU and selecting the next PC and write-back.
module exec_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        reg_write_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write_en,
    output logic [31:0] alu_result,
    output logic        branch_taken
);
    localparam logic [4:0] ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_AND = 5'b00010,
                           ALU_OR  = 5'b00011, ALU_XOR = 5'b00100, ALU_NOR = 5'b00101,
                           ALU_SLT = 5'b00110, ALU_SLL = 5'b01000, ALU_SRL = 5'b01001,
                           ALU_SRA = 5'b01010, ALU_LUI = 5'b01011, ALU_NONE = 5'b11111;

    logic [5:0]  op, fn;
    logic [4:0]  shamt, alu_op;
    logic [31:0] sext, zext, b, pc_plus4, br_target, j_target;
    logic        rw, mw, rdst, is_jr, is_j, is_jal, is_lw, is_beq, is_bne;

    assign op        = instr[31:26];
    assign fn        = instr[5:0];
    assign shamt     = instr[10:6];
    assign sext      = {{16{instr[15]}}, instr[15:0]};
    assign zext      = {16'h0000, instr[15:0]};
    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + {sext[29:0], 2'b00};
    assign j_target  = {pc[31:28], instr[25:0], 2'b00};

    always_comb begin
        alu_op = ALU_NONE;
        b      = rd2;
        rw     = 1'b0;
        mw     = 1'b0;
        rdst   = 1'b0;
        is_jr  = 1'b0;
        is_j   = 1'b0;
        is_jal = 1'b0;
        is_lw  = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        case (op)
            6'h00: begin
                rdst = 1'b1;
                rw   = 1'b1;
                case (fn)
                    6'h20: alu_op = ALU_ADD;
                    6'h22: alu_op = ALU_SUB;
                    6'h24: alu_op = ALU_AND;
                    6'h25: alu_op = ALU_OR;
                    6'h26: alu_op = ALU_XOR;
                    6'h27: alu_op = ALU_NOR;
                    6'h2A: alu_op = ALU_SLT;
                    6'h00: alu_op = ALU_SLL;
                    6'h02: alu_op = ALU_SRL;
                    6'h03: alu_op = ALU_SRA;
                    6'h08: begin
                        rw    = 1'b0;
                        is_jr = 1'b1;
                    end
                    default: rw = 1'b0;
                endcase
            end
            6'h08: begin alu_op = ALU_ADD; b = sext; rw = 1'b1; end
            6'h0A: begin alu_op = ALU_SLT; b = sext; rw = 1'b1; end
            6'h0C: begin alu_op = ALU_AND; b = zext; rw = 1'b1; end
            6'h0D: begin alu_op = ALU_OR;  b = zext; rw = 1'b1; end
            6'h0E: begin alu_op = ALU_XOR; b = zext; rw = 1'b1; end
            6'h0F: begin alu_op = ALU_LUI; rw = 1'b1; end
            6'h23: begin alu_op = ALU_ADD; b = sext; rw = 1'b1; is_lw = 1'b1; end
            6'h2B: begin alu_op = ALU_ADD; b = sext; mw = 1'b1; end
            6'h04: begin alu_op = ALU_SUB; is_beq = 1'b1; end
            6'h05: begin alu_op = ALU_SUB; is_bne = 1'b1; end
            6'h02: is_j = 1'b1;
            6'h03: begin is_jal = 1'b1; rw = 1'b1; end
            default: ;
        endcase
    end

    // Shifts always operate on rd2, independent of the immediate operand path.
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_result = rd1 + b;
            ALU_SUB: alu_result = rd1 - b;
            ALU_AND: alu_result = rd1 & b;
            ALU_OR:  alu_result = rd1 | b;
            ALU_XOR: alu_result = rd1 ^ b;
            ALU_NOR: alu_result = ~(rd1 | b);
            ALU_SLT: alu_result = {31'd0, $signed(rd1) < $signed(b)};
            ALU_SLL: alu_result = rd2 << shamt;
            ALU_SRL: alu_result = rd2 >> shamt;
            ALU_SRA: alu_result = $signed(rd2) >>> shamt;
            ALU_LUI: alu_result = {instr[15:0], 16'h0000};
            default: alu_result = 32'h0;
        endcase
    end

    assign branch_taken = (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2);
    assign pc_next      = is_jr ? rd1 : (is_j || is_jal) ? j_target :
                          branch_taken ? br_target : pc_plus4;
    assign rs_addr      = instr[25:21];
    assign rt_addr      = instr[20:16];
    assign wr_addr      = is_jal ? 5'd31 : rdst ? instr[15:11] : instr[20:16];
    assign wr_data      = is_jal ? pc_plus4 : is_lw ? mem_rdata : alu_result;
    assign reg_write_en = rw && reset_n;
    assign mem_write_en = mw && reset_n;
    assign mem_addr     = alu_result;
    assign mem_wdata    = rd2;

    always_ff @(posedge clock)
        pc <= !reset_n ? RESET_PC : pc_next;
endmodule

// File: tb/tb_exec_core.sv
// tb_exec_core: directed vectors with literal expectations plus a per-cycle
// comparison against an instruction-level model of the core.
module tb_exec_core;
    logic        clock, reset_n;
    logic [31:0] instr, rd1, rd2, mem_rdata;
    logic [31:0] pc, pc_next, wr_data, mem_addr, mem_wdata, alu_result;
    logic [4:0]  rs_addr, rt_addr, wr_addr;
    logic        reg_write_en, mem_write_en, branch_taken;
    int          checks = 0, failures = 0;
    logic        armed = 1'b0;
    logic [31:0] exp_pc;

    typedef struct packed {
        logic [31:0] res, nxt, wd;
        logic [4:0]  wa;
        logic        we, me, bt, rv;
    } exp_t;
    exp_t cur;

    exec_core dut (
        .clock(clock), .reset_n(reset_n), .instr(instr), .rd1(rd1), .rd2(rd2),
        .mem_rdata(mem_rdata), .pc(pc), .pc_next(pc_next), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .wr_addr(wr_addr), .wr_data(wr_data),
        .reg_write_en(reg_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write_en(mem_write_en), .alu_result(alu_result), .branch_taken(branch_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction semantics straight from the ISA: what each instruction computes.
    function automatic exp_t model(input logic [31:0] i, p, a, b, m, input logic rn);
        exp_t e;
        logic [31:0] se, ze, p4;
        logic [4:0] sh;
        se = {{16{i[15]}}, i[15:0]};
        ze = {16'h0, i[15:0]};
        p4 = p + 32'd4;
        sh = i[10:6];
        e = '0;
        e.nxt = p4;
        e.rv = 1'b1;
        e.wa = i[20:16];
        case (i[31:26])
            6'h00: begin
                e.wa = i[15:11];
                e.we = 1'b1;
                case (i[5:0])
                    6'h20: e.res = a + b;
                    6'h22: e.res = a - b;
                    6'h24: e.res = a & b;
                    6'h25: e.res = a | b;
                    6'h26: e.res = a ^ b;
                    6'h27: e.res = ~(a | b);
                    6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: e.res = b << sh;
                    6'h02: e.res = b >> sh;
                    6'h03: e.res = $signed(b) >>> sh;
                    6'h08: begin e.we = 1'b0; e.rv = 1'b0; e.nxt = a; end
                    default: e.we = 1'b0;
                endcase
            end
            6'h08: begin e.res = a + se; e.we = 1'b1; end
            6'h0A: begin e.res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; e.we = 1'b1; end
            6'h0C: begin e.res = a & ze; e.we = 1'b1; end
            6'h0D: begin e.res = a | ze; e.we = 1'b1; end
            6'h0E: begin e.res = a ^ ze; e.we = 1'b1; end
            6'h0F: begin e.res = {i[15:0], 16'h0}; e.we = 1'b1; end
            6'h23: begin e.res = a + se; e.we = 1'b1; end
            6'h2B: begin e.res = a + se; e.me = 1'b1; end
            6'h04, 6'h05: begin
                e.res = a - b;
                e.bt = (i[26] ? (a != b) : (a == b));
                if (e.bt) e.nxt = p4 + (se << 2);
            end
            6'h02: begin e.rv = 1'b0; e.nxt = {p[31:28], i[25:0], 2'b00}; end
            6'h03: begin
                e.rv = 1'b0;
                e.nxt = {p[31:28], i[25:0], 2'b00};
                e.we = 1'b1;
                e.wa = 5'd31;
            end
            default: ;
        endcase
        e.wd = (i[31:26] == 6'h03) ? p4 : (i[31:26] == 6'h23) ? m : e.res;
        if (!rn) begin e.we = 1'b0; e.me = 1'b0; end
        return e;
    endfunction

    assign cur = model(instr, exp_pc, rd1, rd2, mem_rdata, reset_n);

    always @(posedge clock) exp_pc <= reset_n ? cur.nxt : 32'h0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    always @(negedge clock) if (armed) begin
        chk("m_pc", pc, exp_pc);
        chk("m_pc_next", pc_next, cur.nxt);
        chk("m_rs_addr", {27'd0, rs_addr}, {27'd0, instr[25:21]});
        chk("m_rt_addr", {27'd0, rt_addr}, {27'd0, instr[20:16]});
        chk("m_reg_we", {31'd0, reg_write_en}, {31'd0, cur.we});
        chk("m_mem_we", {31'd0, mem_write_en}, {31'd0, cur.me});
        chk("m_branch", {31'd0, branch_taken}, {31'd0, cur.bt});
        chk("m_mem_wdata", mem_wdata, rd2);
        if (cur.rv) begin
            chk("m_alu", alu_result, cur.res);
            chk("m_mem_addr", mem_addr, cur.res);
        end
        if (cur.we) begin
            chk("m_wr_addr", {27'd0, wr_addr}, {27'd0, cur.wa});
            chk("m_wr_data", wr_data, cur.wd);
        end
    end

    function automatic logic [31:0] r_t(input logic [4:0] s, t, d, sh, input logic [5:0] f);
        return {6'h00, s, t, d, sh, f};
    endfunction
    function automatic logic [31:0] i_t(input logic [5:0] o, input logic [4:0] s, t, input logic [15:0] im);
        return {o, s, t, im};
    endfunction
    function automatic logic [31:0] j_t(input logic [5:0] o, input logic [25:0] tg);
        return {o, tg};
    endfunction

    task automatic step(input logic [31:0] i, a, b, m);
        @(posedge clock);
        #1;
        instr = i; rd1 = a; rd2 = b; mem_rdata = m;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        instr = r_t(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
        rd1 = 32'd5; rd2 = 32'd7; mem_rdata = 32'h0;
        @(posedge clock);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_reg_we", {31'd0, reg_write_en}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_write_en}, 32'd0);
        armed = 1'b1;
        reset_n = 1'b1;
        #1;
        chk("add_wa", {27'd0, wr_addr}, 32'd3);
        chk("add_wd", wr_data, 32'd12);
        chk("add_we", {31'd0, reg_write_en}, 32'd1);
        chk("add_nxt", pc_next, 32'd4);

        step(r_t(1, 2, 6, 0, 6'h22), 32'hF0F0_0000, 32'h0000_00FF, 0);
        chk("sub", alu_result, 32'hF0EF_FF01);
        step(r_t(1, 2, 6, 0, 6'h24), 32'hF0F0_0000, 32'h0000_00FF, 0);
        chk("and", alu_result, 32'h0);
        step(r_t(1, 2, 6, 0, 6'h25), 32'hF0F0_0000, 32'h0000_00FF, 0);
        chk("or", alu_result, 32'hF0F0_00FF);
        step(r_t(1, 2, 6, 0, 6'h26), 32'hF0F0_0000, 32'h0000_00FF, 0);
        chk("xor", alu_result, 32'hF0F0_00FF);
        step(r_t(1, 2, 6, 0, 6'h27), 32'hF0F0_0000, 32'h0000_00FF, 0);
        chk("nor", alu_result, 32'h0F0F_FF00);
        step(r_t(1, 2, 6, 0, 6'h2A), 32'hFFFF_FFFF, 32'h1, 0);
        chk("slt", alu_result, 32'h1);
        step(r_t(1, 2, 6, 4, 6'h03), 0, 32'h8000_0000, 0);
        chk("sra", alu_result, 32'hF800_0000);
        step(r_t(1, 2, 6, 4, 6'h02), 0, 32'h8000_0000, 0);
        chk("srl", alu_result, 32'h0800_0000);
        step(r_t(1, 2, 6, 4, 6'h00), 0, 32'h0000_00FF, 0);
        chk("sll", alu_result, 32'h0000_0FF0);
        step(i_t(6'h0F, 0, 5, 16'h1234), 0, 0, 0);
        chk("lui", alu_result, 32'h1234_0000);
        chk("lui_wa", {27'd0, wr_addr}, 32'd5);
        step(i_t(6'h0C, 1, 5, 16'h8F0F), 32'hF0F0_FFFF, 0, 0);
        chk("andi_zext", alu_result, 32'h0000_8F0F);
        step(i_t(6'h08, 1, 5, 16'hFFFF), 32'h10, 0, 0);
        chk("addi_sext", alu_result, 32'hF);

        step(i_t(6'h23, 1, 4, 16'd8), 32'h100, 32'h0, 32'hDEAD_BEEF);
        chk("lw_addr", mem_addr, 32'h108);
        chk("lw_wa", {27'd0, wr_addr}, 32'd4);
        chk("lw_wd", wr_data, 32'hDEAD_BEEF);
        step(i_t(6'h2B, 1, 4, 16'hFFFC), 32'h100, 32'hCAFE_0001, 0);
        chk("sw_addr", mem_addr, 32'hFC);
        chk("sw_wdata", mem_wdata, 32'hCAFE_0001);
        chk("sw_mwe", {31'd0, mem_write_en}, 32'd1);
        chk("sw_rwe", {31'd0, reg_write_en}, 32'd0);

        step(j_t(6'h02, 26'h10), 0, 0, 0);
        chk("j_nxt", pc_next, 32'h40);
        step(i_t(6'h04, 1, 2, 16'hFFFE), 32'd9, 32'd9, 0);
        chk("beq_pc", pc, 32'h40);
        chk("beq_bt", {31'd0, branch_taken}, 32'd1);
        chk("beq_nxt", pc_next, 32'h3C);
        step(j_t(6'h02, 26'h10), 0, 0, 0);
        step(i_t(6'h04, 1, 2, 16'hFFFE), 32'd9, 32'd8, 0);
        chk("beq_nt_nxt", pc_next, 32'h44);
        step(j_t(6'h02, 26'h10), 0, 0, 0);
        step(i_t(6'h05, 1, 2, 16'hFFFE), 32'd9, 32'd8, 0);
        chk("bne_nxt", pc_next, 32'h3C);

        step(r_t(1, 0, 0, 0, 6'h08), 32'h1000_0010, 0, 0);
        chk("jr_hi_nxt", pc_next, 32'h1000_0010);
        step(j_t(6'h03, 26'h40), 0, 0, 0);
        chk("jal_pc", pc, 32'h1000_0010);
        chk("jal_wa", {27'd0, wr_addr}, 32'd31);
        chk("jal_wd", wr_data, 32'h1000_0014);
        chk("jal_nxt", pc_next, 32'h1000_0100);
        step(r_t(1, 0, 0, 0, 6'h08), 32'h2000, 0, 0);
        chk("jr_nxt", pc_next, 32'h2000);
        chk("jr_we", {31'd0, reg_write_en}, 32'd0);

        step({6'h3F, 26'h3FF_FFFF}, 32'h5, 32'h6, 0);
        chk("ill_rwe", {31'd0, reg_write_en}, 32'd0);
        chk("ill_mwe", {31'd0, mem_write_en}, 32'd0);
        chk("ill_nxt", pc_next, 32'h2004);
        step(r_t(1, 2, 3, 0, 6'h3F), 32'h5, 32'h6, 0);
        chk("ill_fn_rwe", {31'd0, reg_write_en}, 32'd0);
        chk("ill_fn_nxt", pc_next, 32'h2008);
        step(r_t(1, 0, 0, 0, 6'h08), 32'h3003, 0, 0);
        chk("jr_unaligned", pc_next, 32'h3003);

        step(r_t(1, 2, 3, 0, 6'h20), 32'd1, 32'd2, 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", {31'd0, reg_write_en}, 32'd0);
        @(posedge clock);
        #1;
        chk("mid_rst_pc", pc, 32'h0);
        reset_n = 1'b1;
        step(r_t(1, 2, 3, 0, 6'h20), 32'd1, 32'd2, 0);
        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
